// File: rtl/branch_pred_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Optional statistics counters are built when BTB_STATS_EN is defined.
module branch_pred_btb #(
    parameter int PC_W     = 16,
    parameter int IDX_W    = 4,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 2,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lookup_en,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic              upd_is_br,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_target,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc
`ifdef BTB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_mispred
`endif
);

    localparam int N     = 2 ** IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 1;
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_INI = CTR_W'(INIT_CTR);
    localparam logic [PC_W-1:0]  PC_TWO  = PC_W'(2);

    logic [N-1:0]     r_valid;
    logic [TAG_W-1:0] r_tag [N];
    logic [PC_W-1:0]  r_tgt [N];
    logic [CTR_W-1:0] r_ctr [N];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_act_taken;
    logic [PC_W-1:0]  w_act_next;

    assign w_lk_idx = lookup_pc[IDX_W:1];
    assign w_lk_tag = lookup_pc[PC_W-1:IDX_W+1];
    assign w_up_idx = upd_pc[IDX_W:1];
    assign w_up_tag = upd_pc[PC_W-1:IDX_W+1];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // Lookup reads the stored arrays directly; no bypass from a same-cycle update.
    always_comb begin
        pred_hit    = !rst && r_valid[w_lk_idx]
                      && (r_tag[w_lk_idx] == w_lk_tag);
        pred_taken  = pred_hit && r_ctr[w_lk_idx][CTR_W-1];
        pred_target = pred_taken ? r_tgt[w_lk_idx]
                                 : lookup_pc + PC_TWO;
    end

    // Resolution check against what IF predicted for this instruction.
    always_comb begin
        w_act_taken = upd_is_br && upd_taken;
        w_act_next  = w_act_taken ? upd_target : upd_pc + PC_TWO;
        mispredict  = upd_valid
                      && ((upd_pred_taken != w_act_taken)
                      || (w_act_taken && (upd_pred_target != upd_target)));
        redirect_pc = w_act_next;
    end

    // Valid bits and counters: reset wins, then train or allocate or evict.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < N; i++) r_ctr[i] <= '0;
        end else if (upd_valid) begin
            if (upd_is_br && w_up_hit) begin
                if (upd_taken && r_ctr[w_up_idx] != CTR_MAX)
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 1'b1;
                else if (!upd_taken && r_ctr[w_up_idx] != '0)
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 1'b1;
            end else if (upd_is_br && upd_taken) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= CTR_INI;
            end else if (!upd_is_br && w_up_hit) begin
                r_valid[w_up_idx] <= 1'b0;
            end
        end
    end

    // Tags and targets need no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_is_br && upd_taken) begin
            r_tgt[w_up_idx] <= upd_target;
            if (!w_up_hit) r_tag[w_up_idx] <= w_up_tag;
        end
    end

`ifdef BTB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_mispred <= '0;
        end else begin
            if (lookup_en && stat_lookups != STAT_MAX)
                stat_lookups <= stat_lookups + 1'b1;
            if (lookup_en && pred_hit && stat_hits != STAT_MAX)
                stat_hits <= stat_hits + 1'b1;
            if (mispredict && stat_mispred != STAT_MAX)
                stat_mispred <= stat_mispred + 1'b1;
        end
    end
`endif

endmodule
